rf_access_ctrl: RTL

RF_ACCESS_CTRL -- requirements
Module: rf_access_ctrl

---
 rtl/rf_access_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/rf_access_ctrl.sv
`timescale 1ns / 1ps
// Register file access controller: clears the register file after reset, then
// accepts one write and one dual-operand read per cycle. Reads return through a
// one-deep response buffer with same-cycle write-to-read bypass.
module rf_access_ctrl #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned INIT_EN = 1
) (
    input  logic            clk,
    input  logic            rstn,
    // write request
    input  logic            wr_valid,
    output logic            wr_ready,
    input  logic [4:0]      wr_addr,
    input  logic [XLEN-1:0] wr_data,
    // read request
    input  logic            rd_valid,
    output logic            rd_ready,
    input  logic [4:0]      rd_rs1,
    input  logic [4:0]      rd_rs2,
    // read response
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rs1_data,
    output logic [XLEN-1:0] rsp_rs2_data,
    output logic            init_done,
    // register file side
    output logic [4:0]      raddr_rs1,
    output logic [4:0]      raddr_rs2,
    input  logic [XLEN-1:0] rdata_rs1,
    input  logic [XLEN-1:0] rdata_rs2,
    output logic [4:0]      waddr_rd,
    output logic [XLEN-1:0] wdata_rd,
    output logic            we
);

    typedef enum logic {StInit, StRun} state_e;

    localparam state_e     ResetState    = (INIT_EN != 0) ? StInit : StRun;
    localparam logic       ResetInitDone = (INIT_EN != 0) ? 1'b0 : 1'b1;

    state_e            state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic              init_done_q, init_done_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0]   rsp_rs1_q, rsp_rs1_d;
    logic [XLEN-1:0]   rsp_rs2_q, rsp_rs2_d;

    // Ungated internal strobes; only the ports are additionally masked by rstn
    // so that the reset net never feeds a flop data input.
    logic              run;
    logic              we_run;
    logic              rd_ready_int;
    logic              rd_accept;
    logic [XLEN-1:0]   op1, op2;

    // Port-side decode: sweep writes during INIT, pass-through writes in RUN
    always_comb begin
        run          = (state_q == StRun);
        we_run       = wr_valid && (wr_addr != 5'd0);
        rd_ready_int = run && (!rsp_valid_q || rsp_ready);
        rd_accept    = rd_valid && rd_ready_int;

        wr_ready  = run && rstn;
        rd_ready  = rd_ready_int && rstn;
        raddr_rs1 = rd_rs1;
        raddr_rs2 = rd_rs2;

        if (run) begin
            we       = we_run && rstn;
            waddr_rd = wr_addr;
            wdata_rd = wr_data;
        end else begin
            we       = rstn;
            waddr_rd = cnt_q;
            wdata_rd = '0;
        end
    end

    // Operand select: x0 reads zero, then same-cycle write bypass, then the file
    always_comb begin
        if (rd_rs1 == 5'd0) begin
            op1 = '0;
        end else if (we_run && (wr_addr == rd_rs1)) begin
            op1 = wr_data;
        end else begin
            op1 = rdata_rs1;
        end

        if (rd_rs2 == 5'd0) begin
            op2 = '0;
        end else if (we_run && (wr_addr == rd_rs2)) begin
            op2 = wr_data;
        end else begin
            op2 = rdata_rs2;
        end
    end

    // Next-state: sweep counter, INIT->RUN transition and response buffer
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rs1_d   = rsp_rs1_q;
        rsp_rs2_d   = rsp_rs2_q;

        if (state_q == StInit) begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
                state_d     = StRun;
                init_done_d = 1'b1;
            end
        end

        if (rd_accept) begin
            rsp_valid_d = 1'b1;
            rsp_rs1_d   = op1;
            rsp_rs2_d   = op2;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ResetState;
            cnt_q       <= 5'd1;
            init_done_q <= ResetInitDone;
            rsp_valid_q <= 1'b0;
            rsp_rs1_q   <= '0;
            rsp_rs2_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rs1_q   <= rsp_rs1_d;
            rsp_rs2_q   <= rsp_rs2_d;
        end
    end

    assign init_done    = init_done_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rs1_data = rsp_rs1_q;
    assign rsp_rs2_data = rsp_rs2_q;

endmodule
